data_mem_arbiter: RTL and testbench

Arbitrates the single data-memory port between four requesters: GPR X/Y port (0), accumulator STA/LDA port (1), stack/PC push-pop port (2) and crypto data port (3).
- Replaces the per-source write strobes currently feeding data_mem with one serialized access stream.
- Uses round-robin arbitration and a fixed 3-cycle access sequence, and returns read data to the owning requester.
- Sits between the control unit / datapath sources and data_mem.

---
 rtl/data_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: four-way arbiter serializing GPR, accumulator, stack and
// crypto accesses onto the single data_mem port.
//
// Each access runs IDLE -> ACCESS -> RESP (3 cycles). The winner is picked
// round-robin from r_rr_ptr. Address, data and direction are latched at the
// IDLE->ACCESS edge. The write happens at the ACCESS->RESP edge. Read data from
// the synchronous memory is valid during RESP and is returned on o_rdata.
//
// Optional feature: define CRYPTO_PRIORITY_EN to give requester 3 absolute
// priority. Requesters 0-2 keep round-robin among themselves, and a crypto
// grant leaves r_rr_ptr untouched.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req, i_we             per-requester request / write flag
//   i_addr_in, i_wdata_in   packed per-requester address / write data
//   o_gnt, o_rvalid         one-hot grant / read-valid pulses
//   o_rdata                 shared read data (zero unless o_rvalid != 0)
//   o_mem_*                 registered memory port; i_mem_rdata = memory output
//   o_busy, o_owner         busy in ACCESS/RESP, last granted requester
module data_mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_req,
    input  logic [3:0]        i_we,
    input  logic [4*AW-1:0]   i_addr_in,
    input  logic [4*DW-1:0]   i_wdata_in,
    output logic [3:0]        o_gnt,
    output logic [3:0]        o_rvalid,
    output logic [DW-1:0]     o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [AW-1:0]     o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    input  logic [DW-1:0]     i_mem_rdata,
    output logic              o_busy,
    output logic [1:0]        o_owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t         r_state;
    logic [1:0]     r_rr_ptr;
    logic [1:0]     r_owner;
    logic [3:0]     r_gnt;
    logic [3:0]     r_rvalid;
    logic           r_mem_en;
    logic           r_mem_we;
    logic [AW-1:0]  r_mem_addr;
    logic [DW-1:0]  r_mem_wdata;
    logic           r_busy;

    logic [3:0]     w_rr_req;
    logic           w_crypto;
    logic [1:0]     w_rr_win;
    logic [1:0]     w_winner;
    logic           w_we_k;
    logic [AW-1:0]  w_addr_k;
    logic [DW-1:0]  w_wdata_k;

`ifdef CRYPTO_PRIORITY_EN
    // Crypto bypasses the rotation; mask it out of the round-robin pool.
    assign w_crypto = i_req[3];
    assign w_rr_req = {1'b0, i_req[2:0]};
`else
    assign w_crypto = 1'b0;
    assign w_rr_req = i_req;
`endif

    // Scan from the farthest offset down so the nearest set bit to r_rr_ptr wins.
    always_comb begin
        w_rr_win = r_rr_ptr;
        for (int i = 3; i >= 0; i--)
            if (w_rr_req[r_rr_ptr + 2'(i)]) w_rr_win = r_rr_ptr + 2'(i);
    end

    assign w_winner  = w_crypto ? 2'd3 : w_rr_win;
    assign w_we_k    = i_we[w_winner];
    assign w_addr_k  = i_addr_in[int'(w_winner)*AW +: AW];
    assign w_wdata_k = i_wdata_in[int'(w_winner)*DW +: DW];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 2'd0;
            r_owner     <= 2'd0;
            r_gnt       <= 4'd0;
            r_rvalid    <= 4'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|i_req) begin
                    r_state     <= ACCESS;
                    r_gnt       <= 4'b1 << w_winner;
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= w_we_k;
                    r_mem_addr  <= w_addr_k;
                    r_mem_wdata <= w_wdata_k;
                    r_busy      <= 1'b1;
                    r_owner     <= w_winner;
                    if (!w_crypto) r_rr_ptr <= w_winner + 2'd1;
                end
                ACCESS: begin
                    // r_gnt still holds the one-hot owner; reuse it for rvalid.
                    r_state  <= RESP;
                    r_gnt    <= 4'd0;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_rvalid <= r_mem_we ? 4'd0 : r_gnt;
                end
                RESP: begin
                    r_state  <= IDLE;
                    r_rvalid <= 4'd0;
                    r_busy   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_rvalid    = r_rvalid;
    assign o_rdata     = |r_rvalid ? i_mem_rdata : '0;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;
    assign o_owner     = r_owner;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random checks of data_mem_arbiter against a transaction-level model.
module tb_data_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req = 4'd0;
    logic [3:0]        we = 4'd0;
    logic [4*AW-1:0]   addr_in = '0;
    logic [4*DW-1:0]   wdata_in = '0;
    logic [3:0]        gnt;
    logic [3:0]        rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              busy;
    logic [1:0]        owner;

    logic [DW-1:0]     mem [512];
    logic [DW-1:0]     ref_mem [512];
    int                tests = 0;
    int                fails = 0;
    int                ptr = 0;
    int                age [4];

    data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we),
        .i_addr_in(addr_in), .i_wdata_in(wdata_in),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef CRYPTO_PRIORITY_EN
        if (r[3]) return 3;
        r[3] = 1'b0;
`endif
        for (int o = 0; o < 4; o++)
            if (r[(p + o) % 4]) return (p + o) % 4;
        return 0;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        we[i] = w;
        addr_in[i*AW +: AW] = a;
        wdata_in[i*DW +: DW] = d;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt === 4'd0 && n < 12);
    endtask

    // One full access: predict the winner, check ACCESS, then check RESP.
    task automatic round(input bit drop, input int exp_wait);
        int k, n;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic w;
        k = pick(req, ptr);
        a = addr_in[k*AW +: AW];
        d = wdata_in[k*DW +: DW];
        w = we[k];
        wait_gnt(n);
        chk("gnt", 32'(gnt), 32'(1) << k);
        if (exp_wait > 0) chk("spacing", n, exp_wait);
        chk("mem_en", 32'(mem_en), 1);
        chk("mem_we", 32'(mem_we), 32'(w));
        chk("mem_addr", 32'(mem_addr), 32'(a));
        chk("mem_wdata", 32'(mem_wdata), 32'(d));
        chk("busy_acc", 32'(busy), 1);
        chk("owner", 32'(owner), k);
        chk("rdata_idle", 32'(rdata), 0);
`ifndef CRYPTO_PRIORITY_EN
        for (int i = 0; i < 4; i++)
            if (i == k) age[i] = 0;
            else if (req[i]) begin
                age[i]++;
                chk("fairness", 32'(age[i] <= 3), 1);
            end
        ptr = (k + 1) % 4;
`else
        if (k != 3) ptr = (k + 1) % 4;
`endif
        if (drop) req[k] = 1'b0;
        if (w) ref_mem[a] = d;
        @(negedge clk);
        chk("rvalid", 32'(rvalid), w ? 32'(0) : (32'(1) << k));
        chk("rdata", 32'(rdata), w ? 32'(0) : 32'(ref_mem[a]));
        chk("mem_en_resp", 32'(mem_en), 0);
        chk("gnt_resp", 32'(gnt), 0);
        chk("busy_resp", 32'(busy), 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) begin
            mem[i] = DW'(i * 16'h1357) ^ 16'hA5A5;
            ref_mem[i] = DW'(i * 16'h1357) ^ 16'hA5A5;
        end
        for (int i = 0; i < 4; i++) age[i] = 0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(9'h040 + i), DW'(i));
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);

        rst_n = 1'b1;
        round(0, 1);
        repeat (4) round(0, 2);

        req = 4'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) age[i] = 0;
        set_req(1, 1'b1, 9'h010, 16'hBEEF);
        round(1, -1);
        set_req(1, 1'b0, 9'h010, 16'h0000);
        round(1, -1);
        chk("beef_mem", 32'(mem[9'h010]), 32'h0000BEEF);

        set_req(2, 1'b0, 9'h033, 16'h1111);
        round(1, -1);
        set_req(0, 1'b1, 9'h034, 16'h2222);
        set_req(2, 1'b0, 9'h034, 16'h3333);
        round(1, -1);
        round(1, -1);
        set_req(0, 1'b0, 9'h034, 16'h4444);
        set_req(3, 1'b1, 9'h035, 16'h5555);
        round(1, -1);
        round(1, -1);

        set_req(3, 1'b0, 9'h1FF, 16'h0000);
        round(1, -1);

        set_req(1, 1'b0, 9'h020, 16'h0000);
        wait_gnt(n);
        chk("mid_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_mem_en", 32'(mem_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        req = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr = 0;
        for (int i = 0; i < 4; i++) age[i] = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_rvalid", 32'(rvalid), 0);
            chk("idle_mem_en", 32'(mem_en), 0);
        end
        set_req(0, 1'b0, 9'h021, 16'h0000);
        set_req(1, 1'b0, 9'h022, 16'h0000);
        round(1, -1);
        round(1, -1);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
            if (req == 4'd0)
                set_req(int'($urandom_range(0, 3)), 1'($urandom), AW'($urandom), DW'($urandom));
            round(1, -1);
        end

        req = 4'd0;
        repeat (2) @(negedge clk);
        chk("end_busy", 32'(busy), 0);
        chk("end_gnt", 32'(gnt), 0);
        chk("end_mem_en", 32'(mem_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
